// File: rtl/uengine_spi_pkg.sv
// Shared definitions for the uEngine SPI master: FSM state encoding and frame field layout.
package uengine_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DONE     = 3'd5
  } spi_state_t;

  localparam int FRAME_W   = 32;
  localparam int RX_W      = 16;
  localparam int READ_BIT  = 31;
  localparam int CHIP_MSB  = 30;
  localparam int CHIP_LSB  = 28;
  localparam int ENG_MSB   = 27;
  localparam int ENG_LSB   = 24;
  localparam int REG_MSB   = 23;
  localparam int REG_LSB   = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // Active-low one-hot select for a 3-bit chip index.
  function automatic logic [7:0] chip_sel_n(input logic [2:0] chip);
    logic [7:0] sel;
    sel = 8'hFF;
    sel[chip] = 1'b0;
    return sel;
  endfunction

endpackage

// File: rtl/uengine_spi_master_if.sv
// Host request/response and SPI pin bundle; SPI_LOOPBACK exists only with SPI_LOOPBACK_EN.
interface uengine_spi_master_if;
  logic [31:0] SPI_TX;
  logic        SPI_START;
  logic        SPI_DONE;
  logic [15:0] SPI_RX;
  logic        SPI_BUSY;
  logic        SPI_SCLK;
  logic        SPI_MOSI;
  logic        SPI_MISO;
  logic [7:0]  SPI_CS_N;
`ifdef SPI_LOOPBACK_EN
  logic        SPI_LOOPBACK;
`endif

  modport master (
    input  SPI_TX, SPI_START, SPI_MISO,
`ifdef SPI_LOOPBACK_EN
    input  SPI_LOOPBACK,
`endif
    output SPI_DONE, SPI_RX, SPI_BUSY, SPI_SCLK, SPI_MOSI, SPI_CS_N
  );

  modport slave (
    output SPI_TX, SPI_START, SPI_MISO,
`ifdef SPI_LOOPBACK_EN
    output SPI_LOOPBACK,
`endif
    input  SPI_DONE, SPI_RX, SPI_BUSY, SPI_SCLK, SPI_MOSI, SPI_CS_N
  );
endinterface

// File: rtl/uengine_spi_clkgen.sv
// SCLK half-period tick generator: pulses every CLK_DIV cycles while enabled, restarts when disabled.
module uengine_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic SysClock,
  input  logic SysReset_N,
  input  logic en,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge SysClock or negedge SysReset_N) begin
    if (!SysReset_N)      cnt <= '0;
    else if (!en)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 8'd1;
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/uengine_spi_master.sv
// uEngine SPI master, mode 0, 32-bit frames. Optional internal loopback under SPI_LOOPBACK_EN.
module uengine_spi_master
  import uengine_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input logic                  SysClock,
  input logic                  SysReset_N,
  uengine_spi_master_if.master spi
);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  spi_state_t          state;
  logic [FRAME_W-1:0]  tx_sh;
  logic [RX_W-1:0]     rx_sh;
  logic [5:0]          bit_cnt;
  logic [7:0]          phase_cnt;
  logic                tick;
  logic                clk_en;
  logic                din;
  logic [7:0]          cs_start;

`ifdef SPI_LOOPBACK_EN
  assign din      = spi.SPI_LOOPBACK ? spi.SPI_MOSI : spi.SPI_MISO;
  assign cs_start = spi.SPI_LOOPBACK ? 8'hFF : chip_sel_n(spi.SPI_TX[CHIP_MSB:CHIP_LSB]);
`else
  assign din      = spi.SPI_MISO;
  assign cs_start = chip_sel_n(spi.SPI_TX[CHIP_MSB:CHIP_LSB]);
`endif

  assign clk_en = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);

  uengine_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .SysClock   (SysClock),
    .SysReset_N (SysReset_N),
    .en         (clk_en),
    .tick       (tick)
  );

  always_ff @(posedge SysClock or negedge SysReset_N) begin
    if (!SysReset_N) begin
      state        <= ST_IDLE;
      tx_sh        <= '0;
      rx_sh        <= '0;
      bit_cnt      <= '0;
      phase_cnt    <= '0;
      spi.SPI_CS_N <= 8'hFF;
      spi.SPI_SCLK <= 1'b0;
      spi.SPI_MOSI <= 1'b0;
      spi.SPI_DONE <= 1'b0;
      spi.SPI_BUSY <= 1'b0;
      spi.SPI_RX   <= '0;
    end else begin
      spi.SPI_DONE <= 1'b0;
      case (state)
        // START coinciding with the DONE pulse is dropped; a fresh START is needed.
        ST_IDLE: if (spi.SPI_START && !spi.SPI_DONE) begin
          tx_sh        <= spi.SPI_TX;
          spi.SPI_MOSI <= spi.SPI_TX[READ_BIT];
          spi.SPI_CS_N <= cs_start;
          spi.SPI_BUSY <= 1'b1;
          bit_cnt      <= '0;
          phase_cnt    <= '0;
          state        <= ST_SETUP;
        end
        ST_SETUP: begin
          if (phase_cnt == SETUP_LAST) state <= ST_SHIFT_LO;
          else                         phase_cnt <= phase_cnt + 8'd1;
        end
        ST_SHIFT_LO: if (tick) begin
          spi.SPI_SCLK <= 1'b1;
          rx_sh        <= {rx_sh[RX_W-2:0], din};
          state        <= ST_SHIFT_HI;
        end
        // Falling edge: advance MOSI, or leave for HOLD after the 32nd bit.
        ST_SHIFT_HI: if (tick) begin
          spi.SPI_SCLK <= 1'b0;
          if (bit_cnt == 6'd31) begin
            spi.SPI_MOSI <= 1'b0;
            phase_cnt    <= '0;
            state        <= ST_HOLD;
          end else begin
            bit_cnt      <= bit_cnt + 6'd1;
            tx_sh        <= {tx_sh[FRAME_W-2:0], 1'b0};
            spi.SPI_MOSI <= tx_sh[FRAME_W-2];
            state        <= ST_SHIFT_LO;
          end
        end
        ST_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            spi.SPI_CS_N <= 8'hFF;
            spi.SPI_RX   <= rx_sh;
            state        <= ST_DONE;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          spi.SPI_DONE <= 1'b1;
          spi.SPI_BUSY <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uengine_spi_master.md
UENGINE_SPI_MASTER -- requirements
Module: uengine_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in SysClock cycles (legal 2..255).
REQ-002 Parameter CS_SETUP, default 2, SysClock cycles from CS assertion to the first SCLK half-period.
REQ-003 Parameter CS_HOLD, default 2, SysClock cycles from the last SCLK falling edge to CS deassertion.
REQ-004 SysClock  in  1  sole clock; all logic on rising edge.
REQ-005 SysReset_N  in  1  reset, asynchronous and active-low.
REQ-006 SPI_TX  in  32  frame: [31] read flag, [30:28] chip index, [27:24] engine index, [23:16] register address, [15:0] write data.
REQ-007 SPI_START  in  1  one-cycle request pulse; sampled only in IDLE.
REQ-008 SPI_DONE  out  1  one-cycle pulse at frame completion.
REQ-009 SPI_RX  out  16  last 16 MISO bits of the most recent frame.
REQ-010 SPI_BUSY  out  1  high in every state except IDLE.
REQ-011 SPI_SCLK  out  1  serial clock, mode 0 (idle low).
REQ-012 SPI_MOSI  out  1  serial data out, MSB first.
REQ-013 SPI_MISO  in  1  serial data in.
REQ-014 SPI_CS_N  out  8  per-chip active-low selects.

Function
REQ-015 On SPI_START in IDLE, the block SHALL latch SPI_TX into a 32-bit shift register and decode [30:28] into one-hot SPI_CS_N.
REQ-016 The FSM SHALL use states IDLE -> SETUP (CS_SETUP cycles) -> SHIFT_LO (CLK_DIV cycles) <-> SHIFT_HI (CLK_DIV cycles) x32 -> HOLD (CS_HOLD cycles) -> DONE (1 cycle) -> IDLE.
REQ-017 MOSI SHALL present bit 31 from SETUP entry and change only on SCLK falling edges; MISO SHALL be sampled on SCLK rising edges.
REQ-018 SPI_DONE SHALL go high exactly 1+CS_SETUP+64*CLK_DIV+CS_HOLD cycles after the edge that samples SPI_START (261 with defaults).
REQ-019 SPI_RX SHALL update on entry to DONE, for read and write frames alike, and hold until the next DONE.
REQ-020 SPI_START while busy SHALL be ignored, with no queueing and no effect on the running frame.
REQ-021 SPI_START in the same cycle as DONE SHALL be ignored; a new frame needs START while in IDLE.
REQ-022 The 6-bit bit counter SHALL count 0..31 and SHALL NOT wrap mid-frame; exit to HOLD occurs after the 32nd falling edge.
REQ-023 Exactly one SPI_CS_N bit SHALL be low from SETUP through HOLD; all SHALL be high in IDLE and DONE.

Reset
REQ-024 During reset the outputs SHALL be: SPI_CS_N=8'hFF, SPI_SCLK=0, SPI_MOSI=0, SPI_DONE=0, SPI_BUSY=0, SPI_RX=16'h0000, FSM=IDLE.
REQ-025 Reset asserted mid-frame SHALL abort immediately with no DONE pulse; the first START after release begins a clean frame.

Configuration
REQ-026 With SPI_LOOPBACK_EN defined, an input SPI_LOOPBACK (1 bit) SHALL exist.
REQ-027 With SPI_LOOPBACK_EN defined and SPI_LOOPBACK high, the sampled data SHALL be internal MOSI and SPI_CS_N SHALL stay 8'hFF; SCLK, timing and DONE are unchanged.
REQ-028 Without SPI_LOOPBACK_EN, the port and mux SHALL be absent and SPI_MISO SHALL always be sampled.

Structure
REQ-029 Package uengine_spi_pkg SHALL hold the FSM state encoding and the frame field positions (read flag, chip, engine, register, data).
REQ-030 Sub-module uengine_spi_clkgen SHALL generate the CLK_DIV half-period tick; the FSM consumes only that tick.

Verification
REQ-031 Default params; SPI_TX=32'h9A10_0000; MISO model returns 16'hFF05 in bits 15:0 -> SPI_CS_N=8'hFD, 32 SCLK pulses, SPI_RX=16'hFF05, DONE 261 cycles after START.
REQ-032 Write frame SPI_TX=32'h0340_1234 -> MOSI bitstream equals 32'h0340_1234 MSB first, SPI_CS_N=8'hFE.
REQ-033 Second START at cycle 100 of an active frame -> ignored; exactly one DONE, SPI_RX from the first frame.
REQ-034 SysReset_N low at cycle 50 of a frame -> SPI_CS_N=8'hFF and SCLK=0 immediately, no DONE; next frame completes correctly.
REQ-035 SPI_LOOPBACK_EN defined, SPI_LOOPBACK=1, SPI_TX=32'h8000_BEEF -> SPI_RX=16'hBEEF, SPI_CS_N stays 8'hFF.
REQ-036 CLK_DIV=2, CS_SETUP=1, CS_HOLD=1 -> DONE 131 cycles after START.
